// File: rtl/mem_access_unit.sv
// mem_access_unit: buffers pipeline load/store requests in a small FIFO and
// issues them one at a time to a stalling cache port. Each access gets one
// response strobe. Misaligned accesses and accesses that stall too long
// return an error response.
module mem_access_unit #(
  parameter int DEPTH   = 2,    // request buffer entries, power of 2, >= 2
  parameter int TIMEOUT = 255   // max stalled cycles per access, 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [9:0]  WordAddress,
  output logic [31:0] DataIn,
  input  logic        stall,
  input  logic [31:0] DataOut
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  // Request FIFO storage and bookkeeping
  logic          fifo_we    [DEPTH];
  logic [11:0]   fifo_addr  [DEPTH];
  logic [31:0]   fifo_wdata [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic          push, pop;
  logic          fifo_empty;
  logic          head_we;
  logic [11:0]   head_addr;
  logic [31:0]   head_wdata;
  logic          head_aligned;
  logic          in_aligned;

  logic [7:0]    stall_cnt;
  logic          timed_out;

  logic          load_rsp;
  logic [31:0]   rsp_rdata_next;
  logic          rsp_err_next;

  assign fifo_empty   = (count == '0);
  assign req_ready    = (count != (AW+1)'(DEPTH));
  assign push         = req_valid & req_ready;
  assign head_we      = fifo_we[rd_ptr];
  assign head_addr    = fifo_addr[rd_ptr];
  assign head_wdata   = fifo_wdata[rd_ptr];
  assign head_aligned = (head_addr[1:0] == 2'b00);
  assign in_aligned   = (req_addr[1:0] == 2'b00);
  assign timed_out    = stall && (stall_cnt == 8'(TIMEOUT - 1));

  // FIFO payload write; the entries need no reset because count gates every read
  // NOTE: storage arrays are deliberately left out of the reset branch; only
  // the pointers and count that qualify them are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wr_ptr]    <= req_we;
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_wdata[wr_ptr] <= req_wdata;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, FIFO pop and response capture decisions
  // NOTE: every signal written here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    load_rsp       = 1'b0;
    rsp_rdata_next = '0;
    rsp_err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_aligned) begin
            state_next = ACCESS;
          end else begin
            pop          = 1'b1;
            load_rsp     = 1'b1;
            rsp_err_next = 1'b1;
            state_next   = RESP;
          end
        end else if (push && in_aligned) begin
          // Empty buffer: an aligned arrival goes straight to the cache
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (!stall) begin
          pop            = 1'b1;
          load_rsp       = 1'b1;
          rsp_rdata_next = head_we ? 32'h0 : DataOut;
          state_next     = RESP;
        end else if (timed_out) begin
          pop          = 1'b1;
          load_rsp     = 1'b1;
          rsp_err_next = 1'b1;
          state_next   = RESP;
        end
      end
      RESP: begin
        if (!fifo_empty) state_next = head_aligned ? ACCESS : IDLE;
        else if (push && in_aligned) state_next = ACCESS;
        else state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stall counter: zero outside ACCESS, so it is clear on every entry; saturates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state != ACCESS) begin
      stall_cnt <= '0;
    end else if (stall && !timed_out) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  // Response payload captured on the edge that finishes an access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (load_rsp) begin
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
    end
  end

  // Cache port driven from the FIFO head only while an access is outstanding
  always_comb begin
    rsp_valid   = (state == RESP);
    mem_read    = (state == ACCESS) && !head_we;
    mem_write   = (state == ACCESS) && head_we;
    WordAddress = (state == ACCESS) ? head_addr[11:2] : 10'h0;
    DataIn      = ((state == ACCESS) && head_we) ? head_wdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit. Two instances: the default-parameter
// unit carries most tests; a TIMEOUT=4 unit covers the stall abort.
module tb_mem_access_unit;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_valid_t = 1'b0;
  logic        req_we = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall = 1'b0;
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_val = '0;

  logic        req_ready, req_ready_t;
  logic        rsp_valid, rsp_valid_t;
  logic [31:0] rsp_rdata, rsp_rdata_t;
  logic        rsp_err, rsp_err_t;
  logic        mem_read, mem_read_t;
  logic        mem_write, mem_write_t;
  logic [9:0]  word_address, word_address_t;
  logic [31:0] data_in, data_in_t;
  logic [31:0] data_out, data_out_t;

  rsp_t q[$];
  rsp_t q_t[$];
  rsp_t e_m, e_t;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Cache stub: read data is a fixed pattern tagged with the word address
  function automatic logic [31:0] exp_load(input logic [11:0] a);
    return {20'hC0DE0, 2'b00, a[11:2]};
  endfunction

  always_comb data_out   = use_fixed ? fixed_val : {20'hC0DE0, 2'b00, word_address};
  always_comb data_out_t = {20'hC0DE0, 2'b00, word_address_t};

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .WordAddress(word_address),
    .DataIn(data_in), .stall(stall), .DataOut(data_out)
  );

  mem_access_unit #(.DEPTH(2), .TIMEOUT(4)) dut_t (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_t), .req_ready(req_ready_t), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_t), .rsp_rdata(rsp_rdata_t), .rsp_err(rsp_err_t),
    .mem_read(mem_read_t), .mem_write(mem_write_t), .WordAddress(word_address_t),
    .DataIn(data_in_t), .stall(stall), .DataOut(data_out_t)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the default unit
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (q.size() == 0) begin
        check("spurious_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e_m = q.pop_front();
        check("rsp_rdata", rsp_rdata, e_m.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e_m.err));
      end
    end
  end

  // Monitor for the TIMEOUT=4 unit
  always @(negedge clk) begin
    if (!reset && rsp_valid_t) begin
      if (q_t.size() == 0) begin
        check("spurious_rsp_t", 32'(rsp_valid_t), 32'd0);
      end else begin
        e_t = q_t.pop_front();
        check("rsp_rdata_t", rsp_rdata_t, e_t.rdata);
        check("rsp_err_t", 32'(rsp_err_t), 32'(e_t.err));
      end
    end
  end

  task automatic expect_rsp(input bit tgt, input logic [31:0] rdata, input logic err);
    rsp_t r;
    r.rdata = rdata;
    r.err   = err;
    if (tgt) q_t.push_back(r);
    else     q.push_back(r);
  endtask

  // Present one request at the first negedge with ready high; accepted at the next posedge
  task automatic send(input bit tgt, input logic we, input logic [11:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    bit done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (tgt ? req_ready_t : req_ready) begin
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        if (tgt) req_valid_t = 1'b1;
        else     req_valid   = 1'b1;
        expect_rsp(tgt, rdata, err);
        done = 1'b1;
      end else begin
        req_valid   = 1'b0;
        req_valid_t = 1'b0;
      end
    end
    if (!done) check("send_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q.size() + q_t.size()) != 0; i++) @(negedge clk);
    check("drain", 32'(q.size() + q_t.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_word_address", 32'(word_address), 32'd0);
    check("rst_data_in", data_in, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Load hit: mem_read one cycle after accept, response the cycle after
    use_fixed = 1'b1;
    fixed_val = 32'hDEADBEEF;
    stall     = 1'b0;
    send(1'b0, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    check("hit_mem_read", 32'(mem_read), 32'd1);
    check("hit_mem_write", 32'(mem_write), 32'd0);
    check("hit_word_address", 32'(word_address), 32'h4);
    @(negedge clk);
    check("hit_rsp_valid", 32'(rsp_valid), 32'd1);
    check("hit_mem_read_off", 32'(mem_read), 32'd0);
    drain();
    use_fixed = 1'b0;

    // Store miss: five stalled cycles, write held six cycles
    stall = 1'b1;
    send(1'b0, 1'b1, 12'h3FC, 32'h12345678, 32'h0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      check("miss_mem_write", 32'(mem_write), 32'd1);
      check("miss_mem_read", 32'(mem_read), 32'd0);
      check("miss_word_address", 32'(word_address), 32'h0FF);
      check("miss_data_in", data_in, 32'h12345678);
      check("miss_no_rsp", 32'(rsp_valid), 32'd0);
      stall = (i < 6);
    end
    @(negedge clk);
    check("miss_rsp_valid", 32'(rsp_valid), 32'd1);
    check("miss_mem_write_off", 32'(mem_write), 32'd0);
    drain();

    // Back-pressure: two requests fill the buffer while the first stalls
    stall = 1'b1;
    send(1'b0, 1'b0, 12'h020, 32'h0, exp_load(12'h020), 1'b0);
    send(1'b0, 1'b1, 12'h024, 32'h0BADF00D, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    check("full_ready", 32'(req_ready), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("full_ready_held", 32'(req_ready), 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    check("ready_after_pop", 32'(req_ready), 32'd1);
    send(1'b0, 1'b0, 12'h028, 32'h0, exp_load(12'h028), 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    // Streamed mix of loads and stores: pointers wrap several times
    for (int k = 0; k < 6; k++) begin
      logic [11:0] a;
      a = 12'h100 + 12'(4 * k);
      send(1'b0, k[0], a, 32'h50000000 + 32'(k), k[0] ? 32'h0 : exp_load(a), 1'b0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    // Misaligned: no cache access, error response two cycles after accept
    send(1'b0, 1'b0, 12'h013, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    check("mis_no_access", {30'd0, mem_read, mem_write}, 32'd0);
    check("mis_no_rsp_yet", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("mis_rsp_valid", 32'(rsp_valid), 32'd1);
    check("mis_no_access2", {30'd0, mem_read, mem_write}, 32'd0);
    drain();

    // Timeout on the TIMEOUT=4 unit, followed by a normal load
    stall = 1'b1;
    send(1'b1, 1'b0, 12'h040, 32'h0, 32'h0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("to_mem_read", 32'(mem_read_t), 32'd1);
      check("to_word_address", 32'(word_address_t), 32'h010);
      if (i == 1) begin
        check("to_ready", 32'(req_ready_t), 32'd1);
        req_addr = 12'h044;
        req_we   = 1'b0;
        expect_rsp(1'b1, exp_load(12'h044), 1'b0);
      end else begin
        req_valid_t = 1'b0;
      end
    end
    @(negedge clk);
    check("to_mem_read_off", 32'(mem_read_t), 32'd0);
    check("to_rsp_valid", 32'(rsp_valid_t), 32'd1);
    stall = 1'b0;
    drain();

    // Reset pulse mid-access drops everything with no response
    stall = 1'b1;
    send(1'b0, 1'b0, 12'h080, 32'h0, 32'h0, 1'b0);
    send(1'b0, 1'b0, 12'h084, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_mem_read", 32'(mem_read), 32'd1);
    check("pre_rst_word_address", 32'(word_address), 32'h020);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_mem_read", 32'(mem_read), 32'd0);
    check("rst_mid_word_address", 32'(word_address), 32'd0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    q.delete();
    q_t.delete();
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_idle", {30'd0, mem_read, rsp_valid}, 32'd0);

    // Unit works normally after the reset
    send(1'b0, 1'b0, 12'h0C0, 32'h0, exp_load(12'h0C0), 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning request buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning maximum stall cycles per access before abort (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  pipeline request present.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 SHALL have port req_we  input  1  1=store, 0=load.
REQ-008 SHALL have port req_addr  input  12  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_err  output  1  misaligned or timed-out access; qualified by rsp_valid.
REQ-013 SHALL have port mem_read  output  1  cache read request.
REQ-014 SHALL have port mem_write  output  1  cache write request.
REQ-015 SHALL have port WordAddress  output  10  word address = req_addr[11:2].
REQ-016 SHALL have port DataIn  output  32  store data to cache.
REQ-017 SHALL have port stall  input  1  cache busy (miss/refill in progress).
REQ-018 SHALL have port DataOut  input  32  cache read data.

Function
REQ-019 SHALL buffer requests in a DEPTH-entry FIFO (we, addr, wdata); req_ready = FIFO not full; push on req_valid & req_ready.
REQ-020 SHALL implement FSM IDLE, ACCESS, RESP; reset state IDLE.
REQ-021 IDLE: FIFO non-empty with aligned head (addr[1:0]==0) -> ACCESS next cycle; misaligned head -> pop, RESP with rsp_err=1, no cache access.
REQ-022 ACCESS: SHALL drive mem_read=~we or mem_write=we (never both), WordAddress and DataIn from FIFO head, held constant until completion.
REQ-023 Completion SHALL be any ACCESS cycle with stall=0; on that edge capture DataOut (loads), pop head, go to RESP.
REQ-024 SHALL count consecutive ACCESS cycles with stall=1; when count reaches TIMEOUT with stall still 1, deassert mem_read/mem_write, pop head, go to RESP with rsp_err=1.
REQ-025 Stall counter SHALL clear on entry to ACCESS and never wrap.
REQ-026 RESP: rsp_valid=1 exactly one cycle; then ACCESS directly if next head is aligned, else IDLE (where REQ-021 applies).
REQ-027 mem_read, mem_write SHALL be 0 in IDLE and RESP; exactly one access outstanding at a time.
REQ-028 Minimum latency SHALL be: accept at edge N, mem_read/mem_write high cycle N+1, rsp_valid cycle N+2 when stall=0.
REQ-029 Simultaneous push and pop SHALL be allowed; count unchanged; full FIFO SHALL accept again the cycle after a pop.
REQ-030 Responses SHALL return in acceptance order.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH without loss.

Reset
REQ-032 On reset assertion, asynchronously: FSM IDLE, FIFO empty, stall counter 0, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_read=0, mem_write=0, WordAddress=0, DataIn=0.
REQ-033 Reset mid-ACCESS SHALL drop the in-flight and buffered requests with no response.

Verification
REQ-034 Load hit: req addr 0x010, we=0, stall=0, DataOut=0xDEADBEEF -> mem_read high with WordAddress=4 one cycle, next cycle rsp_valid=1, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-035 Store miss: we=1, addr 0x3FC, wdata 0x12345678, stall=1 for 5 cycles -> mem_write, WordAddress=0xFF, DataIn held 6 cycles, then one rsp_valid with rsp_err=0, rsp_rdata=0.
REQ-036 Back-pressure: 3 back-to-back requests with DEPTH=2 and stall=1 -> req_ready=0 while full; all 3 responses in order.
REQ-037 Timeout: TIMEOUT=4, stall held 1 -> mem_read drops after 4 stall cycles, rsp_valid with rsp_err=1, next request proceeds.
REQ-038 Misaligned: addr 0x013 -> no mem_read/mem_write, rsp_valid with rsp_err=1 two cycles after accept.
REQ-039 Reset pulse during ACCESS -> all outputs at reset values immediately, no rsp_valid after release.
